// File: rtl/pe_edge_source.sv
// Boundary "ghost PE": replays a preloaded {addr,data} table onto a PE neighbour
// input one record per sort step, and captures the PE's output at each step end.
module pe_edge_source #(
  parameter int ADDR_WIDTH     = 3,
  parameter int DATA_WIDTH     = 3,
  parameter int DEPTH          = 8,
  parameter int SORT_CYCLES    = 1,
  parameter int COMPUTE_CYCLES = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wr_en,
  input  logic [$clog2(DEPTH)-1:0]           wr_idx,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0]   wr_rec,
  input  logic                               start,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0]   i_PE,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0]   o_PE,
  output logic                               busy,
  output logic                               done,
  input  logic [$clog2(DEPTH)-1:0]           cap_idx,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0]   cap_rec
);

  localparam int W       = ADDR_WIDTH + DATA_WIDTH;
  localparam int IW      = $clog2(DEPTH);
  localparam int CNT_MAX = (SORT_CYCLES > COMPUTE_CYCLES) ? SORT_CYCLES : COMPUTE_CYCLES;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  typedef enum logic [1:0] {IDLE, SORT, COMPUTE, DONE} state_t;

  state_t          state_q;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    o_pe_q;
  logic            busy_q, done_q;
  logic [W-1:0]    tbl_q [DEPTH];
  logic [W-1:0]    cap_q [DEPTH];
  logic            sort_end, comp_end;

  assign idx_d    = idx_q + IW'(1);
  assign sort_end = (cnt_q == CW'(SORT_CYCLES - 1));
  assign comp_end = (cnt_q == CW'(COMPUTE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      o_pe_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          o_pe_q <= '0;
          if (start) begin
            state_q <= SORT;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            // a same-cycle write to entry 0 must be visible to the first record
            o_pe_q  <= (wr_en && wr_idx == '0) ? wr_rec : tbl_q[0];
          end
        end
        SORT: begin
          if (sort_end) begin
            cnt_q <= '0;
            if (idx_q == IW'(DEPTH - 1)) begin
              state_q <= COMPUTE;
              o_pe_q  <= '0;
            end else begin
              idx_q  <= idx_d;
              o_pe_q <= tbl_q[idx_d];
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        COMPUTE: begin
          if (comp_end) begin
            cnt_q   <= '0;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

  // Tables are storage only; reset never touches them.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && wr_en)
      tbl_q[wr_idx] <= wr_rec;
    if (state_q == SORT && sort_end)
      cap_q[idx_q] <= i_PE;
  end

  assign o_PE    = o_pe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cap_rec = cap_q[cap_idx];

endmodule

// File: tb/tb_pe_edge_source.sv
// Directed bench for pe_edge_source: default geometry plus a DEPTH=4, 3-cycle hold variant.
`timescale 1ns/1ps
module tb_pe_edge_source;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, start, busy, done;
  logic [2:0] wr_idx, cap_idx;
  logic [5:0] wr_rec, i_pe, o_pe, cap_rec;
  logic       wr_en4, start4, busy4, done4;
  logic [1:0] wr_idx4, cap_idx4;
  logic [5:0] wr_rec4, i_pe4, o_pe4, cap_rec4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pe_edge_source u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_rec(wr_rec),
    .start(start), .i_PE(i_pe), .o_PE(o_pe), .busy(busy), .done(done),
    .cap_idx(cap_idx), .cap_rec(cap_rec)
  );

  pe_edge_source #(.DEPTH(4), .SORT_CYCLES(3), .COMPUTE_CYCLES(2)) u_dut4 (
    .clk(clk), .rst(rst), .wr_en(wr_en4), .wr_idx(wr_idx4), .wr_rec(wr_rec4),
    .start(start4), .i_PE(i_pe4), .o_PE(o_pe4), .busy(busy4), .done(done4),
    .cap_idx(cap_idx4), .cap_rec(cap_rec4)
  );

  function automatic logic [5:0] rec8(int k);
    return {k[2:0], 3'(7 - k)};
  endfunction

  function automatic logic [5:0] rec4(int k);
    return {3'(k + 1), 3'(2 * k)};
  endfunction

  function automatic logic [5:0] capv4(int k);
    return {3'(k), 3'b101};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick(); tick();
    checks++; if (o_pe !== 6'd0) begin failures++; $display("FAIL reset_ope got=%h exp=0", o_pe); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", busy, done); end
    checks++; if (o_pe4 !== 6'd0 || busy4 !== 1'b0 || done4 !== 1'b0) begin failures++; $display("FAIL reset_dut4 got=%h %b%b exp=0 00", o_pe4, busy4, done4); end
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (o_pe !== 6'd0 || busy !== 1'b0 || done !== 1'b0) begin
        failures++; $display("FAIL idle_hold c=%0d got=%h %b%b exp=0 00", c, o_pe, busy, done);
      end
    end
  endtask

  task automatic test_replay_default;
    for (int k = 0; k < 8; k++) begin
      wr_en = 1'b1; wr_idx = 3'(k); wr_rec = rec8(k);
      tick();
    end
    wr_en = 1'b0;
    i_pe = 6'b000_011;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      logic [5:0] eo;
      eo = (c <= 8) ? rec8(c - 1) : 6'd0;
      checks++; if (o_pe !== eo) begin failures++; $display("FAIL replay_ope c=%0d got=%h exp=%h", c, o_pe, eo); end
      checks++; if (busy !== (c <= 9)) begin failures++; $display("FAIL replay_busy c=%0d got=%b exp=%b", c, busy, (c <= 9)); end
      checks++; if (done !== (c == 10)) begin failures++; $display("FAIL replay_done c=%0d got=%b exp=%b", c, done, (c == 10)); end
      tick();
    end
  endtask

  task automatic test_capture_default;
    for (int i = 0; i < 8; i++) begin
      cap_idx = 3'(i);
      #1;
      checks++; if (cap_rec !== 6'b000_011) begin failures++; $display("FAIL capture idx=%0d got=%h exp=03", i, cap_rec); end
    end
  endtask

  task automatic test_slow_steps;
    for (int k = 0; k < 4; k++) begin
      wr_en4 = 1'b1; wr_idx4 = 2'(k); wr_rec4 = rec4(k);
      tick();
    end
    wr_en4 = 1'b0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      logic [5:0] eo;
      int p, k;
      p = (c - 1) % 3;
      k = (c - 1) / 3;
      if (c <= 12) begin
        if (p == 0) i_pe4 = 6'b111_000;
        if (p == 2) i_pe4 = capv4(k);
      end
      eo = (c <= 12) ? rec4(k) : 6'd0;
      checks++; if (o_pe4 !== eo) begin failures++; $display("FAIL slow_ope c=%0d got=%h exp=%h", c, o_pe4, eo); end
      checks++; if (busy4 !== (c <= 14)) begin failures++; $display("FAIL slow_busy c=%0d got=%b exp=%b", c, busy4, (c <= 14)); end
      checks++; if (done4 !== (c == 15)) begin failures++; $display("FAIL slow_done c=%0d got=%b exp=%b", c, done4, (c == 15)); end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      cap_idx4 = 2'(i);
      #1;
      checks++; if (cap_rec4 !== capv4(i)) begin failures++; $display("FAIL slow_capture idx=%0d got=%h exp=%h", i, cap_rec4, capv4(i)); end
    end
  endtask

  task automatic test_ignored_requests;
    bit seen;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      logic [5:0] eo;
      if (c == 4) begin start = 1'b1; wr_en = 1'b1; wr_idx = 3'd0; wr_rec = 6'b111_111; end
      if (c == 5) begin start = 1'b0; wr_en = 1'b0; end
      eo = (c <= 8) ? rec8(c - 1) : 6'd0;
      checks++; if (o_pe !== eo) begin failures++; $display("FAIL ignore_ope c=%0d got=%h exp=%h", c, o_pe, eo); end
      checks++; if (busy !== (c <= 9) || done !== (c == 10)) begin
        failures++; $display("FAIL ignore_flags c=%0d got=%b%b exp=%b%b", c, busy, done, (c <= 9), (c == 10));
      end
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (o_pe !== rec8(0)) begin failures++; $display("FAIL ignore_rerun got=%h exp=%h", o_pe, rec8(0)); end
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (done) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL ignore_rerun_done got=0 exp=1"); end
    tick();
  endtask

  task automatic test_mid_reset;
    i_pe = 6'b010_101;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    checks++; if (o_pe !== 6'd0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL midrst_out got=%h %b%b exp=0 00", o_pe, busy, done);
    end
    for (int i = 0; i < 8; i++) begin
      logic [5:0] ec;
      ec = (i < 4) ? 6'b010_101 : 6'b000_011;
      cap_idx = 3'(i);
      #1;
      checks++; if (cap_rec !== ec) begin failures++; $display("FAIL midrst_cap idx=%0d got=%h exp=%h", i, cap_rec, ec); end
    end
    tick();
    rst = 1'b1;
    tick();
    i_pe = 6'b110_000;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      logic [5:0] eo;
      eo = (c <= 8) ? rec8(c - 1) : 6'd0;
      checks++; if (o_pe !== eo) begin failures++; $display("FAIL rerun_ope c=%0d got=%h exp=%h", c, o_pe, eo); end
      checks++; if (busy !== (c <= 9) || done !== (c == 10)) begin
        failures++; $display("FAIL rerun_flags c=%0d got=%b%b exp=%b%b", c, busy, done, (c <= 9), (c == 10));
      end
      if (c == 3) begin
        cap_idx = 3'd1; #1;
        checks++; if (cap_rec !== 6'b110_000) begin failures++; $display("FAIL rerun_cap1 got=%h exp=30", cap_rec); end
        cap_idx = 3'd3; #1;
        checks++; if (cap_rec !== 6'b010_101) begin failures++; $display("FAIL rerun_cap3_kept got=%h exp=15", cap_rec); end
        cap_idx = 3'd5; #1;
        checks++; if (cap_rec !== 6'b000_011) begin failures++; $display("FAIL rerun_cap5_kept got=%h exp=03", cap_rec); end
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b0;
    wr_en = 1'b0; wr_idx = '0; wr_rec = '0; start = 1'b0; i_pe = '0; cap_idx = '0;
    wr_en4 = 1'b0; wr_idx4 = '0; wr_rec4 = '0; start4 = 1'b0; i_pe4 = '0; cap_idx4 = '0;
    test_reset();
    test_replay_default();
    test_capture_default();
    test_slow_steps();
    test_ignored_requests();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
